// File: rtl/wr_skid_ctrl.sv
// Write-side skid controller: a 2-entry in-order buffer between an upstream
// valid/ready stream and a FIFO write port, with word/frame/stall counters.
module wr_skid_ctrl #(
   parameter int DATA_WD = 8,
   parameter int CNT_WD  = 16
) (
   input  logic               wclk,
   input  logic               wrst,
   input  logic               s_valid,
   input  logic [DATA_WD-1:0] s_data,
   input  logic               s_last,
   output logic               s_ready,
   input  logic               wfull,
   output logic               winc,
   output logic [DATA_WD-1:0] wdata,
   output logic [1:0]         wstate,
   output logic [CNT_WD-1:0]  wwords,
   output logic [CNT_WD-1:0]  wframes,
   output logic [CNT_WD-1:0]  wstalls
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      STALL = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_WD-1:0] data;
      logic               last;
   } ent_t;

   localparam logic [CNT_WD-1:0] CNT_ONE = {{(CNT_WD-1){1'b0}}, 1'b1};
   localparam logic [CNT_WD-1:0] CNT_MAX = {CNT_WD{1'b1}};

   ent_t              head_q, head_d;
   ent_t              tail_q, tail_d;
   logic [1:0]        occ_q, occ_d;
   state_e            state_q, state_d;
   logic [CNT_WD-1:0] words_q, words_d;
   logic [CNT_WD-1:0] frames_q, frames_d;
   logic [CNT_WD-1:0] stalls_q, stalls_d;

   logic       push, pop, stalled;
   logic [1:0] base;
   ent_t       in_ent;

   // s_ready depends only on registered occupancy, so upstream never sees wfull.
   assign s_ready = (occ_q != 2'd2);
   assign winc    = (occ_q != 2'd0) && !wfull;
   assign wdata   = head_q.data;
   assign wstate  = state_q;
   assign wwords  = words_q;
   assign wframes = frames_q;
   assign wstalls = stalls_q;

   assign push    = s_valid && s_ready;
   assign pop     = winc;
   assign stalled = (occ_q != 2'd0) && wfull;
   assign base    = occ_q - {1'b0, pop};
   assign in_ent  = '{data: s_data, last: s_last};

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
      words_d  = words_q;
      frames_d = frames_q;
      stalls_d = stalls_q;
      state_d  = XFER;

      if (pop) head_d = tail_q;
      // A new word lands in the first free slot after this cycle's pop.
      if (push) begin
         if (base == 2'd0) head_d = in_ent;
         else              tail_d = in_ent;
      end

      if (pop) begin
         words_d = words_q + CNT_ONE;
         if (head_q.last) frames_d = frames_q + CNT_ONE;
      end
      if (stalled && (stalls_q != CNT_MAX)) stalls_d = stalls_q + CNT_ONE;

      if (occ_d == 2'd0) state_d = IDLE;
      else if (wfull)    state_d = STALL;
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         head_q   <= '0;
         tail_q   <= '0;
         occ_q    <= 2'd0;
         state_q  <= IDLE;
         words_q  <= '0;
         frames_q <= '0;
         stalls_q <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         occ_q    <= occ_d;
         state_q  <= state_d;
         words_q  <= words_d;
         frames_q <= frames_d;
         stalls_q <= stalls_d;
      end
   end

endmodule

// File: tb/tb_wr_skid_ctrl.sv
// Directed bench for wr_skid_ctrl: default-width instance plus a CNT_WD=4
// instance for counter wrap and saturation.
module tb_wr_skid_ctrl;

   logic       wclk = 1'b0;
   always #5 wclk = ~wclk;

   logic       wrst, s_valid, s_last, s_ready, wfull, winc;
   logic [7:0] s_data, wdata;
   logic [1:0] wstate;
   logic [15:0] wwords, wframes, wstalls;

   logic       q_rst, q_valid, q_last, q_ready, q_full, q_winc;
   logic [7:0] q_data, q_wdata;
   logic [1:0] q_wstate;
   logic [3:0] q_wwords, q_wframes, q_wstalls;

   wr_skid_ctrl #(.DATA_WD(8), .CNT_WD(16)) dut (
      .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(s_ready), .wfull(wfull), .winc(winc),
      .wdata(wdata), .wstate(wstate), .wwords(wwords), .wframes(wframes),
      .wstalls(wstalls));

   wr_skid_ctrl #(.DATA_WD(8), .CNT_WD(4)) dut4 (
      .wclk(wclk), .wrst(q_rst), .s_valid(q_valid), .s_data(q_data),
      .s_last(q_last), .s_ready(q_ready), .wfull(q_full), .winc(q_winc),
      .wdata(q_wdata), .wstate(q_wstate), .wwords(q_wwords), .wframes(q_wframes),
      .wstalls(q_wstalls));

   int ncmp = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic f);
      s_valid = v;
      s_data  = d;
      s_last  = l;
      wfull   = f;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] fr [4];
      logic       exp_rdy, exp_inc, acc;
      int         nxt, pops;

      fr = '{8'h11, 8'h22, 8'h33, 8'h44};

      wrst = 1'b1; q_rst = 1'b1;
      s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; wfull = 1'b0;
      q_valid = 1'b0; q_data = 8'h00; q_last = 1'b0; q_full = 1'b0;
      tick();
      tick();
      wrst = 1'b0; q_rst = 1'b0;
      #1;
      chk("rst_state",  32'(wstate),  32'd0);
      chk("rst_words",  32'(wwords),  32'd0);
      chk("rst_frames", 32'(wframes), 32'd0);
      chk("rst_stalls", 32'(wstalls), 32'd0);
      chk("rst_ready",  32'(s_ready), 32'd1);
      chk("rst_winc",   32'(winc),    32'd0);

      // 4-word frame, wfull low: one-cycle latency, back-to-back writes
      for (int i = 0; i < 5; i++) begin
         if (i < 4) drive(1'b1, fr[i], (i == 3), 1'b0);
         else       drive(1'b0, 8'h00, 1'b0, 1'b0);
         chk("a_ready", 32'(s_ready), 32'd1);
         chk("a_winc",  32'(winc),    32'(i > 0));
         if (i > 0) chk("a_wdata", 32'(wdata), 32'(fr[i-1]));
         tick();
      end
      chk("a_winc_end", 32'(winc),    32'd0);
      chk("a_state",    32'(wstate),  32'd0);
      chk("a_words",    32'(wwords),  32'd4);
      chk("a_frames",   32'(wframes), 32'd1);
      chk("a_stalls",   32'(wstalls), 32'd0);

      // wfull held: two accepted, third back-pressured, then drain in order
      drive(1'b1, 8'hA1, 1'b0, 1'b1);
      chk("b_ready0", 32'(s_ready), 32'd1);
      chk("b_winc0",  32'(winc),    32'd0);
      tick();
      drive(1'b1, 8'hA2, 1'b0, 1'b1);
      chk("b_ready1", 32'(s_ready), 32'd1);
      chk("b_state1", 32'(wstate),  32'd2);
      tick();
      drive(1'b1, 8'hA3, 1'b1, 1'b1);
      chk("b_ready2", 32'(s_ready), 32'd0);
      chk("b_winc2",  32'(winc),    32'd0);
      chk("b_state2", 32'(wstate),  32'd2);
      tick();
      drive(1'b1, 8'hA3, 1'b1, 1'b0);
      chk("b_ready3", 32'(s_ready), 32'd0);
      chk("b_winc3",  32'(winc),    32'd1);
      chk("b_data3",  32'(wdata),   32'hA1);
      tick();
      chk("b_state4", 32'(wstate),  32'd1);
      chk("b_ready4", 32'(s_ready), 32'd1);
      chk("b_data4",  32'(wdata),   32'hA2);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("b_winc5",  32'(winc),    32'd1);
      chk("b_data5",  32'(wdata),   32'hA3);
      tick();
      chk("b_state",  32'(wstate),  32'd0);
      chk("b_words",  32'(wwords),  32'd7);
      chk("b_frames", 32'(wframes), 32'd2);
      chk("b_stalls", 32'(wstalls), 32'd2);

      // occ=1 with simultaneous push and pop
      drive(1'b1, 8'hB1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 8'hB2, 1'b0, 1'b0);
      chk("c_winc", 32'(winc),  32'd1);
      chk("c_data", 32'(wdata), 32'hB1);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("c_state", 32'(wstate), 32'd1);
      chk("c_next",  32'(wdata),  32'hB2);
      chk("c_winc2", 32'(winc),   32'd1);
      tick();
      chk("c_idle",  32'(winc),   32'd0);
      chk("c_words", 32'(wwords), 32'd9);

      // continuous s_valid with wfull toggling each cycle
      nxt = 0;
      pops = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'(8'h40 + nxt), 1'b0, (i % 2 == 0));
         exp_rdy = !((i % 2 == 1) && (i >= 3));
         exp_inc = (i % 2 == 1);
         chk("d_ready", 32'(s_ready), 32'(exp_rdy));
         chk("d_winc",  32'(winc),    32'(exp_inc));
         if (exp_inc) begin
            chk("d_data", 32'(wdata), 32'(32'h40 + pops));
            pops++;
         end
         acc = s_ready && s_valid;
         tick();
         if (acc) nxt++;
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("d_accepted", 32'(nxt),   32'd11);
      chk("d_drain",    32'(wdata), 32'h4A);
      chk("d_drainv",   32'(winc),  32'd1);
      tick();
      chk("d_words",  32'(wwords),  32'd20);
      chk("d_stalls", 32'(wstalls), 32'd11);
      chk("d_state",  32'(wstate),  32'd0);

      // reset while full and stalled
      drive(1'b1, 8'hC1, 1'b0, 1'b1);
      tick();
      drive(1'b1, 8'hC2, 1'b0, 1'b1);
      tick();
      chk("e_full", 32'(s_ready), 32'd0);
      wrst = 1'b1;
      drive(1'b1, 8'hC3, 1'b1, 1'b1);
      tick();
      wrst = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("e_state",  32'(wstate),  32'd0);
      chk("e_words",  32'(wwords),  32'd0);
      chk("e_frames", 32'(wframes), 32'd0);
      chk("e_stalls", 32'(wstalls), 32'd0);
      chk("e_ready",  32'(s_ready), 32'd1);
      chk("e_winc",   32'(winc),    32'd0);

      // CNT_WD=4: stall counter saturates, word counter wraps
      q_valid = 1'b1; q_data = 8'h90; q_full = 1'b1;
      #1;
      tick();
      q_valid = 1'b0;
      repeat (20) tick();
      chk("f_stalls_sat", 32'(q_wstalls), 32'd15);
      chk("f_state",      32'(q_wstate),  32'd2);
      chk("f_words0",     32'(q_wwords),  32'd0);
      q_full = 1'b0;
      for (int i = 0; i < 16; i++) begin
         q_valid = 1'b1;
         q_data  = 8'(8'h91 + i);
         #1;
         chk("f_winc", 32'(q_winc),  32'd1);
         chk("f_data", 32'(q_wdata), 32'(32'h90 + i));
         tick();
      end
      q_valid = 1'b0;
      #1;
      chk("f_last", 32'(q_wdata), 32'hA0);
      tick();
      chk("f_words_wrap", 32'(q_wwords),  32'd1);
      chk("f_stalls_end", 32'(q_wstalls), 32'd15);
      chk("f_idle",       32'(q_wstate),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/wr_skid_ctrl.md
WR_SKID_CTRL -- requirements
Module: wr_skid_ctrl

Interface
REQ-001 Parameter DATA_WD, default 8: width of data words.
REQ-002 Parameter CNT_WD, default 16: width of word, frame and stall counters.
REQ-003 wclk  input  1: write-domain clock; all state updates on its rising edge.
REQ-004 wrst  input  1: reset, synchronous, active-high.
REQ-005 s_valid  input  1: upstream word valid.
REQ-006 s_data  input  DATA_WD: upstream word.
REQ-007 s_last  input  1: word is last of a frame, qualified by s_valid.
REQ-008 s_ready  output  1: block accepts the word this cycle.
REQ-009 wfull  input  1: FIFO write-side full flag, synchronous to wclk.
REQ-010 winc  output  1: FIFO write strobe, one word per asserted cycle.
REQ-011 wdata  output  DATA_WD: word written when winc=1.
REQ-012 wstate  output  2: FSM state, IDLE=0, XFER=1, STALL=2.
REQ-013 wwords  output  CNT_WD: words written to FIFO, wraps modulo 2^CNT_WD.
REQ-014 wframes  output  CNT_WD: frames completed (last word written), wraps.
REQ-015 wstalls  output  CNT_WD: cycles stalled on wfull, saturates at all-ones.

Function
REQ-016 Block shall hold a 2-entry in-order buffer, each entry {data, last}; occupancy occ in 0..2.
REQ-017 Push shall occur when s_valid && s_ready; s_ready shall equal (occ<2), a function of registered state only (no combinational path from wfull or s_valid).
REQ-018 Pop shall occur when winc; winc shall equal (occ>0) && !wfull; wdata shall equal head entry data, combinationally from registers.
REQ-019 Push and pop in the same cycle shall leave occ unchanged and preserve word order; occ=2 with push is impossible by REQ-017.
REQ-020 Latency: word pushed into empty buffer at edge N shall appear on wdata with winc=1 in cycle after edge N if wfull=0.
REQ-021 With wfull=0 and s_valid held high, throughput shall be one word per cycle with s_ready continuously 1.
REQ-022 wfull asserted shall block pops that cycle; buffered data shall be held unchanged, none lost or duplicated.
REQ-023 FSM next state from next occ and current wfull: occ_next=0 -> IDLE; occ_next>0 && wfull -> STALL; else XFER.
REQ-024 wwords shall increment by 1 on every winc cycle, wrapping all-ones to 0.
REQ-025 wframes shall increment by 1 on every winc cycle whose head entry has last=1, wrapping.
REQ-026 wstalls shall increment on every cycle with occ>0 && wfull, holding at all-ones.
REQ-027 s_last on a non-accepted cycle shall be ignored.

Reset
REQ-028 wrst=1 at a clock edge shall set occ=0, wstate=IDLE, wwords=wframes=wstalls=0, discarding buffered words regardless of in-flight transfer.
REQ-029 During and after reset cycle: winc=0, s_ready=1 (occ=0), wdata don't-care but stable.
REQ-030 Reset shall take priority over simultaneous push, pop or counter updates.

Verification
REQ-031 Reset then 4-word frame D=0x11,0x22,0x33,0x44 (last on 0x44), wfull=0 -> winc 4 consecutive cycles starting 1 cycle after first accept, wdata in order, wwords=4, wframes=1, wstalls=0.
REQ-032 wfull=1 held, push 3 words -> first 2 accepted, s_ready=0 after, winc=0, wstate=STALL; release wfull -> 2 words drain in order, then 3rd accepted.
REQ-033 Continuous s_valid, wfull toggling 1/0 each cycle for 20 cycles -> no loss/duplication, wwords equals accepted count, wstalls equals stalled cycles.
REQ-034 occ=1, simultaneous push and pop -> occ stays 1, next wdata is new word, wstate=XFER.
REQ-035 wrst asserted with occ=2 and wfull=1 -> next cycle occ=0, counters 0, winc=0, s_ready=1, wstate=IDLE.
REQ-036 CNT_WD=4, write 17 words with wfull=1 for 20 cycles beforehand -> wwords=1 (wrapped), wstalls=15 (saturated).
